// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: entry index width,
// instruction class encodings, controller states and the per-entry
// instruction record.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_BIT = 3;
  localparam int ROB_SIZE      = 1 << ROB_WIDTH_BIT;

  typedef enum logic [1:0] {
    TYPE_ALU    = 2'd0,
    TYPE_BRANCH = 2'd1,
    TYPE_STORE  = 2'd2,
    TYPE_LOAD   = 2'd3
  } issue_type_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FLUSH  = 1'b1
  } rob_state_t;

  // Fields captured at issue and never touched by writeback
  typedef struct packed {
    logic [4:0]  rd;
    issue_type_t typ;
    logic [31:0] pc;
    logic        pred;
  } rob_info_t;

  // Fetch target after a mispredicted branch commits
  function automatic logic [31:0] redirect_target(input logic        taken,
                                                  input logic [31:0] target,
                                                  input logic [31:0] pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer_fwd_mux.sv
// Operand lookup for one register-file query. A result arriving on either
// writeback bus this cycle is forwarded ahead of the stored value so the
// consumer does not wait an extra cycle for the entry to update.
module reorder_buffer_fwd_mux
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_WIDTH_BIT-1:0]  query_id,
  input  logic [ROB_SIZE-1:0]       entry_ready,
  input  logic [ROB_SIZE-1:0][31:0] entry_val,
  input  logic                      alu_valid,
  input  logic [ROB_WIDTH_BIT-1:0]  alu_rob_id,
  input  logic [31:0]               alu_val,
  input  logic                      lsb_valid,
  input  logic [ROB_WIDTH_BIT-1:0]  lsb_rob_id,
  input  logic [31:0]               lsb_val,
  output logic                      query_ready,
  output logic [31:0]               query_val
);

  logic alu_match;
  logic lsb_match;

  // Bypass priority: ALU bus, then LSB bus, then the stored entry value
  always_comb begin
    alu_match   = alu_valid && (alu_rob_id == query_id);
    lsb_match   = lsb_valid && (lsb_rob_id == query_id);
    query_ready = entry_ready[query_id] | alu_match | lsb_match;
    if (alu_match) begin
      query_val = alu_val;
    end else if (lsb_match) begin
      query_val = lsb_val;
    end else begin
      query_val = entry_val[query_id];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates an entry per issued instruction,
// collects ALU and load/store results, commits in program order and
// flushes everything for one cycle after a mispredicted branch commits.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [1:0]               issue_type,
  input  logic [31:0]              issue_pc,
  input  logic                     issue_pred_taken,
  input  logic                     issue_ready,
  input  logic [31:0]              issue_val,
  output logic                     rob_full,
  output logic                     issue_accept,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     alu_valid,
  input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
  input  logic [31:0]              alu_val,
  input  logic                     alu_taken,
  input  logic [31:0]              alu_target,
  input  logic                     lsb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_val,
  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     store_commit,
  output logic [ROB_WIDTH_BIT-1:0] store_rob_id,
  output logic                     clear_flag,
  output logic [31:0]              redirect_pc
);

  logic [ROB_WIDTH_BIT-1:0]  head_reg;
  logic [ROB_WIDTH_BIT-1:0]  tail_reg;
  logic [ROB_WIDTH_BIT:0]    count_reg;
  logic [ROB_WIDTH_BIT:0]    count_next;
  rob_state_t                state_reg;
  rob_state_t                state_next;
  logic                      normal_mode;
  logic                      flushing;

  logic [ROB_SIZE-1:0]       busy_vec;
  logic [ROB_SIZE-1:0]       ready_vec;
  logic [ROB_SIZE-1:0]       taken_vec;
  logic [ROB_SIZE-1:0][31:0] val_vec;
  logic [ROB_SIZE-1:0][31:0] target_vec;
  rob_info_t [ROB_SIZE-1:0]  info_vec;

  rob_info_t                 head_info;
  logic                      commit_fire;
  logic                      mispredict;

  // Full is judged on the pre-edge count, so a same-cycle commit never frees
  // a slot for this cycle's issue
  assign rob_full     = (count_reg == (ROB_WIDTH_BIT+1)'(ROB_SIZE));
  assign issue_accept = rdy_in && issue_valid && !rob_full && normal_mode;
  assign new_reg_id   = issue_accept ? issue_rd : 5'd0;
  assign new_ROB_id   = tail_reg;

  assign head_info   = info_vec[head_reg];
  assign commit_fire = rdy_in && normal_mode && busy_vec[head_reg] && ready_vec[head_reg];
  assign mispredict  = commit_fire && (head_info.typ == TYPE_BRANCH)
                       && (taken_vec[head_reg] != head_info.pred);

  // Entry storage: one slot per generate iteration
  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      logic        busy_reg;
      logic        ready_reg;
      logic        taken_reg;
      logic [31:0] val_reg;
      logic [31:0] target_reg;
      rob_info_t   info_reg;
      logic        issue_here;
      logic        commit_here;
      logic        alu_here;
      logic        lsb_here;

      assign issue_here  = issue_accept && (tail_reg == ROB_WIDTH_BIT'(gi));
      assign commit_here = commit_fire && (head_reg == ROB_WIDTH_BIT'(gi));
      assign alu_here    = normal_mode && busy_reg && alu_valid
                           && (alu_rob_id == ROB_WIDTH_BIT'(gi));
      assign lsb_here    = normal_mode && busy_reg && lsb_valid
                           && (lsb_rob_id == ROB_WIDTH_BIT'(gi));

      // Control bits: allocated at issue, marked ready by writeback, released
      // at commit, wiped by reset or flush
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end else if (rdy_in) begin
          if (flushing) begin
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
          end else if (issue_here) begin
            busy_reg  <= 1'b1;
            ready_reg <= issue_ready;
          end else if (commit_here) begin
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
          end else if (alu_here || lsb_here) begin
            ready_reg <= 1'b1;
          end
        end
      end

      // Payload: only meaningful while busy, so it carries no reset
      always_ff @(posedge clk_in) begin
        if (rdy_in) begin
          if (issue_here) begin
            val_reg    <= issue_val;
            taken_reg  <= 1'b0;
            target_reg <= 32'd0;
            info_reg   <= '{rd: issue_rd, typ: issue_type_t'(issue_type),
                            pc: issue_pc, pred: issue_pred_taken};
          end
          if (alu_here) begin
            val_reg    <= alu_val;
            taken_reg  <= alu_taken;
            target_reg <= alu_target;
          end else if (lsb_here) begin
            val_reg    <= lsb_val;
          end
        end
      end

      assign busy_vec[gi]   = busy_reg;
      assign ready_vec[gi]  = ready_reg;
      assign taken_vec[gi]  = taken_reg;
      assign val_vec[gi]    = val_reg;
      assign target_vec[gi] = target_reg;
      assign info_vec[gi]   = info_reg;
    end
  endgenerate

  // Controller state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= ST_NORMAL;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  // Next state: a mispredict commit costs exactly one flush cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NORMAL: if (mispredict) state_next = ST_FLUSH;
      ST_FLUSH:  state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  // State decode used by the datapath
  always_comb begin
    normal_mode = (state_reg == ST_NORMAL);
    flushing    = (state_reg == ST_FLUSH);
  end

  // Occupancy after this cycle's issue and commit
  always_comb begin
    count_next = count_reg;
    case ({issue_accept, commit_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Head/tail pointers and occupancy; a flush restarts allocation at id 0
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      if (flushing) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (issue_accept) tail_reg <= tail_reg + 1'b1;
        if (commit_fire)  head_reg <= head_reg + 1'b1;
        count_reg <= count_next;
      end
    end
  end

  // Commit outputs, registered one edge after the head becomes committable
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      write_reg_id <= '0;
      write_ROB_id <= '0;
      write_val    <= '0;
      store_commit <= 1'b0;
      store_rob_id <= '0;
      clear_flag   <= 1'b0;
      redirect_pc  <= '0;
    end else if (rdy_in) begin
      write_reg_id <= '0;
      store_commit <= 1'b0;
      clear_flag   <= 1'b0;
      if (commit_fire) begin
        write_reg_id <= (head_info.typ == TYPE_STORE) ? 5'd0 : head_info.rd;
        write_ROB_id <= head_reg;
        write_val    <= val_vec[head_reg];
        if (head_info.typ == TYPE_STORE) begin
          store_commit <= 1'b1;
          store_rob_id <= head_reg;
        end
        if (mispredict) begin
          clear_flag  <= 1'b1;
          redirect_pc <= redirect_target(taken_vec[head_reg], target_vec[head_reg],
                                         head_info.pc);
        end
      end
    end
  end

  reorder_buffer_fwd_mux u_fwd_rs1 (
    .query_id    (rs1_id),
    .entry_ready (ready_vec),
    .entry_val   (val_vec),
    .alu_valid   (alu_valid),
    .alu_rob_id  (alu_rob_id),
    .alu_val     (alu_val),
    .lsb_valid   (lsb_valid),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_val     (lsb_val),
    .query_ready (rs1_ready),
    .query_val   (rs1_val)
  );

  reorder_buffer_fwd_mux u_fwd_rs2 (
    .query_id    (rs2_id),
    .entry_ready (ready_vec),
    .entry_val   (val_vec),
    .alu_valid   (alu_valid),
    .alu_rob_id  (alu_rob_id),
    .alu_val     (alu_val),
    .lsb_valid   (lsb_valid),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_val     (lsb_val),
    .query_ready (rs2_ready),
    .query_val   (rs2_val)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model
// predicts acceptance, lookups and commit events; a monitor compares every
// commit/flush the DUT presents against the expected-event queue.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_pred_taken, issue_ready;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_type;
  logic [31:0] issue_pc, issue_val;
  logic        rob_full, issue_accept;
  logic [4:0]  new_reg_id;
  logic [2:0]  new_ROB_id;
  logic        alu_valid, alu_taken, lsb_valid;
  logic [2:0]  alu_rob_id, lsb_rob_id, rs1_id, rs2_id;
  logic [31:0] alu_val, alu_target, lsb_val;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  write_reg_id;
  logic [2:0]  write_ROB_id, store_rob_id;
  logic [31:0] write_val, redirect_pc;
  logic        store_commit, clear_flag;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_type(issue_type),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_ready(issue_ready), .issue_val(issue_val),
    .rob_full(rob_full), .issue_accept(issue_accept),
    .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
    .alu_taken(alu_taken), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
    .store_commit(store_commit), .store_rob_id(store_rob_id),
    .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic [1:0]  typ;
    logic [31:0] pc;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
    logic        taken;
    logic [31:0] target;
  } m_ent_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    int          id;
    logic [31:0] val;
    logic        st;
    logic        clr;
    logic [31:0] redir;
  } ev_t;

  m_ent_t mq[$];      // in-flight instructions, oldest first
  ev_t    exp_q[$];   // expected commit events
  int     m_tail  = 0;
  bit     m_flush = 0;
  int     cyc     = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_query(input logic [2:0] id, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[i]) if (mq[i].id == int'(id)) begin r = mq[i].rdy; v = mq[i].val; end
    if (lsb_valid && lsb_rob_id == id) begin r = 1'b1; v = lsb_val; end
    if (alu_valid && alu_rob_id == id) begin r = 1'b1; v = alu_val; end
  endfunction

  // Check this cycle's combinational outputs, then advance the model past the edge
  task automatic model_cycle();
    logic full, acc, commit, r;
    logic [31:0] v;
    ev_t ev;
    m_ent_t ne;
    full = (mq.size() == ROB_SIZE);
    acc  = rdy_in && issue_valid && !full && !m_flush;
    chk("issue_accept", issue_accept, acc);
    chk("rob_full", rob_full, full);
    chk("new_ROB_id", new_ROB_id, m_tail);
    chk("new_reg_id", new_reg_id, acc ? issue_rd : 5'd0);
    model_query(rs1_id, r, v);
    chk("rs1_ready", rs1_ready, r);
    if (r) chk("rs1_val", rs1_val, v);
    model_query(rs2_id, r, v);
    chk("rs2_ready", rs2_ready, r);
    if (r) chk("rs2_val", rs2_val, v);
    if (!rdy_in) return;
    if (m_flush) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 0;
      return;
    end
    commit = (mq.size() != 0) && mq[0].rdy;
    if (commit) begin
      ev.cyc   = cyc + 1;
      ev.rd    = (mq[0].typ == TYPE_STORE) ? 5'd0 : mq[0].rd;
      ev.id    = mq[0].id;
      ev.val   = mq[0].val;
      ev.st    = (mq[0].typ == TYPE_STORE);
      ev.clr   = (mq[0].typ == TYPE_BRANCH) && (mq[0].taken != mq[0].pred);
      ev.redir = mq[0].taken ? mq[0].target : mq[0].pc + 32'd4;
      exp_q.push_back(ev);
    end
    foreach (mq[i]) begin
      if (alu_valid && mq[i].id == int'(alu_rob_id)) begin
        mq[i].rdy = 1'b1; mq[i].val = alu_val;
        mq[i].taken = alu_taken; mq[i].target = alu_target;
      end else if (lsb_valid && mq[i].id == int'(lsb_rob_id)) begin
        mq[i].rdy = 1'b1; mq[i].val = lsb_val;
      end
    end
    if (commit) begin
      m_flush = ev.clr;
      mq.delete(0);
    end
    if (acc) begin
      ne = '{id: m_tail, rd: issue_rd, typ: issue_type, pc: issue_pc, pred: issue_pred_taken,
             rdy: issue_ready, val: issue_val, taken: 1'b0, target: 32'd0};
      mq.push_back(ne);
      m_tail = (m_tail + 1) % ROB_SIZE;
    end
  endtask

  // One clock cycle; inputs were driven at the preceding negedge
  task automatic step();
    #1;
    if (rst_in) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 0;
    end else begin
      model_cycle();
    end
    @(posedge clk_in);
    cyc++;
  endtask

  task automatic idle_in();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_ready = 1'b0; issue_pred_taken = 1'b0;
    alu_valid = 1'b0; lsb_valid = 1'b0; alu_taken = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic pred, input logic rdy, input logic [31:0] v);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_pred_taken = pred; issue_ready = rdy; issue_val = v;
  endtask

  task automatic set_alu(input logic [2:0] id, input logic [31:0] v, input logic tk,
                         input logic [31:0] tgt);
    alu_valid = 1'b1; alu_rob_id = id; alu_val = v; alu_taken = tk; alu_target = tgt;
  endtask

  task automatic reset_dut();
    @(negedge clk_in); idle_in(); rst_in = 1'b1; step();
    @(negedge clk_in); rst_in = 1'b0;
    #1;
    chk("rst_rob_full", rob_full, 1'b0);
    chk("rst_new_ROB_id", new_ROB_id, 3'd0);
    chk("rst_write_reg_id", write_reg_id, 5'd0);
    chk("rst_store_commit", store_commit, 1'b0);
    chk("rst_clear_flag", clear_flag, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    step();
  endtask

  task automatic rand_inputs();
    int ca[$];
    int cl[$];
    int k;
    logic [1:0] t;
    k = $urandom_range(0, 99);
    t = (k < 50) ? TYPE_ALU : (k < 65) ? TYPE_BRANCH : (k < 80) ? TYPE_STORE : TYPE_LOAD;
    idle_in();
    set_issue(t, (t == TYPE_STORE) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom & 32'hFFFC,
              (t == TYPE_BRANCH) ? 1'($urandom_range(0, 1)) : 1'b0,
              (t == TYPE_ALU) && ($urandom_range(0, 4) == 0), $urandom);
    issue_valid = ($urandom_range(0, 9) < 7);
    foreach (mq[i]) if (!mq[i].rdy) begin
      if (mq[i].typ == TYPE_ALU || mq[i].typ == TYPE_BRANCH) ca.push_back(i);
      else cl.push_back(i);
    end
    if (ca.size() != 0 && $urandom_range(0, 2) != 0) begin
      k = ca[$urandom_range(0, ca.size() - 1)];
      set_alu(3'(mq[k].id), $urandom, 1'($urandom_range(0, 1)), $urandom & 32'hFFFC);
    end else if (mq.size() < ROB_SIZE && $urandom_range(0, 9) == 0) begin
      set_alu(3'(m_tail), $urandom, 1'b1, 32'h0000_0040);
    end
    if (cl.size() != 0 && $urandom_range(0, 2) != 0) begin
      k = cl[$urandom_range(0, cl.size() - 1)];
      lsb_valid = 1'b1; lsb_rob_id = 3'(mq[k].id); lsb_val = $urandom;
    end
    rs1_id = ($urandom_range(0, 3) == 0) ? alu_rob_id : 3'($urandom_range(0, 7));
    rs2_id = ($urandom_range(0, 3) == 0) ? lsb_rob_id : 3'($urandom_range(0, 7));
  endtask

  // Monitor: every commit or flush the DUT presents pops one expected event
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk_in);
      #2;
      if (write_reg_id != 5'd0 || store_commit || clear_flag) begin
        $display("[TB] commit cyc=%0d id=%0d reg=%0d val=%08h store=%0b clear=%0b pc=%08h",
                 cyc, write_ROB_id, write_reg_id, write_val, store_commit, clear_flag, redirect_pc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_commit: got reg=%0d store=%0b clear=%0b, expected no commit",
                   write_reg_id, store_commit, clear_flag);
        end else begin
          ev = exp_q.pop_front();
          chk("commit_cycle", cyc, ev.cyc);
          chk("write_reg_id", write_reg_id, ev.rd);
          chk("write_ROB_id", write_ROB_id, ev.id);
          chk("write_val", write_val, ev.val);
          chk("store_commit", store_commit, ev.st);
          if (ev.st) chk("store_rob_id", store_rob_id, ev.id);
          chk("clear_flag", clear_flag, ev.clr);
          if (ev.clr) chk("redirect_pc", redirect_pc, ev.redir);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rs1_id = '0; rs2_id = '0; issue_rd = '0; issue_type = '0;
    issue_pc = '0; issue_val = '0; alu_rob_id = '0; alu_val = '0; alu_target = '0;
    lsb_rob_id = '0; lsb_val = '0;
    idle_in();
    reset_dut();

    // Fill all eight entries, then a ninth issue is refused
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'(i), 32'(i * 4), 1'b0, 1'b0, 32'(i)); step();
    end
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd9, 32'h24, 1'b0, 1'b0, 32'd9);
    #1;
    chk("full_after_8", rob_full, 1'b1);
    chk("ninth_rejected", issue_accept, 1'b0);
    step();
    reset_dut();

    // Single commit of rd=5 with value 0x2A
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd5, 32'h10, 1'b0, 1'b0, 32'd0); step();
    @(negedge clk_in); idle_in(); set_alu(3'd0, 32'h2A, 1'b0, 32'd0); step();
    @(negedge clk_in); idle_in(); step();
    @(negedge clk_in); idle_in();
    #1;
    chk("t2_write_reg_id", write_reg_id, 5'd5);
    chk("t2_write_ROB_id", write_ROB_id, 3'd0);
    chk("t2_write_val", write_val, 32'h2A);
    chk("t2_empty", new_ROB_id, 3'd1);

    // Same-cycle ALU forward on rs1
    rs1_id = 3'd3; set_alu(3'd3, 32'h77, 1'b0, 32'd0);
    #1;
    chk("fwd_rs1_ready", rs1_ready, 1'b1);
    chk("fwd_rs1_val", rs1_val, 32'h77);
    step();
    reset_dut();

    // Out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'(10 + i), 32'(i * 4), 1'b0, 1'b0, 32'd0); step();
    end
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk_in); idle_in(); set_alu(3'(i), 32'(32'h100 + i), 1'b0, 32'd0); step();
    end
    for (int i = 0; i < 4; i++) begin @(negedge clk_in); idle_in(); step(); end
    reset_dut();

    // Mispredicted branch with two younger entries
    @(negedge clk_in); idle_in(); set_issue(TYPE_BRANCH, 5'd1, 32'h100, 1'b0, 1'b0, 32'd0); step();
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd2, 32'h104, 1'b0, 1'b0, 32'd0); step();
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd3, 32'h108, 1'b0, 1'b1, 32'd3); step();
    @(negedge clk_in); idle_in(); set_alu(3'd0, 32'h104, 1'b1, 32'h200); step();
    @(negedge clk_in); idle_in(); step();
    @(negedge clk_in); idle_in();
    #1;
    chk("br_clear_flag", clear_flag, 1'b1);
    chk("br_redirect_pc", redirect_pc, 32'h200);
    step();
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd4, 32'h200, 1'b0, 1'b0, 32'd0);
    #1;
    chk("after_flush_id", new_ROB_id, 3'd0);
    chk("after_flush_accept", issue_accept, 1'b1);
    step();
    reset_dut();

    // Full ROB, head becomes ready: commit happens, issue waits one cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 32'd0); step();
    end
    @(negedge clk_in); idle_in(); set_alu(3'd0, 32'h55, 1'b0, 32'd0); step();
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd20, 32'h40, 1'b0, 1'b0, 32'd0);
    #1;
    chk("full_commit_reject", issue_accept, 1'b0);
    step();
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd20, 32'h40, 1'b0, 1'b0, 32'd0);
    #1;
    chk("full_next_accept", issue_accept, 1'b1);
    step();
    reset_dut();

    // rdy_in low freezes a ready head and blocks issue
    @(negedge clk_in); idle_in(); set_issue(TYPE_ALU, 5'd9, 32'h0, 1'b0, 1'b1, 32'h99); step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in); idle_in(); rdy_in = 1'b0; set_issue(TYPE_ALU, 5'd7, 32'h4, 1'b0, 1'b0, 32'd0);
      #1;
      chk("rdy_low_no_accept", issue_accept, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin @(negedge clk_in); idle_in(); step(); end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin @(negedge clk_in); rand_inputs(); step(); end

    // Reset landing in the flush cycle
    for (int i = 0; i < 600 && !m_flush; i++) begin @(negedge clk_in); rand_inputs(); step(); end
    reset_dut();
    for (int i = 0; i < 200; i++) begin @(negedge clk_in); rand_inputs(); step(); end
    for (int i = 0; i < 4; i++) begin @(negedge clk_in); idle_in(); step(); end
    #3;
    chk("no_missing_commits", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that allocates an entry per issued instruction and collects results from the ALU and load/store writeback buses.
- Commits in program order and answers operand-readiness queries from the register file.
- Sits beside the register file. It supplies the rename tag (new_reg_id/new_ROB_id) at issue, the commit write (write_reg_id/write_ROB_id/write_val), and the rs1/rs2 forwarding lookups.
- On a committed branch mispredict it broadcasts clear_flag and the redirect PC.

Parameters:
- ROB_WIDTH_BIT, 3, entry index width; ROB_SIZE = 2**ROB_WIDTH_BIT entries (8).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state
- issue_valid  in  1  decoder presents an instruction
- issue_rd  in  5  destination register; 0 = none
- issue_type  in  2  0=ALU, 1=BRANCH, 2=STORE, 3=LOAD
- issue_pc  in  32  PC of the instruction
- issue_pred_taken  in  1  predictor decision (BRANCH only)
- issue_ready  in  1  result already known at issue (e.g. LUI)
- issue_val  in  32  value used when issue_ready
- rob_full  out  1  no entry free; decoder must hold
- issue_accept  out  1  entry allocated this cycle
- new_reg_id  out  5  issue_accept ? issue_rd : 0
- new_ROB_id  out  ROB_WIDTH_BIT  tail index (allocated id)
- alu_valid, alu_rob_id, alu_val, alu_taken, alu_target  in  1/ROB_WIDTH_BIT/32/1/32  ALU writeback
- lsb_valid, lsb_rob_id, lsb_val  in  1/ROB_WIDTH_BIT/32  load-data or store-address-done writeback
- rs1_id, rs2_id  in  ROB_WIDTH_BIT  queried tags
- rs1_ready, rs2_ready  out  1  queried entry result available
- rs1_val, rs2_val  out  32  queried result
- write_reg_id  out  5  commit destination; 0 = no write
- write_ROB_id  out  ROB_WIDTH_BIT  committing entry id
- write_val  out  32  commit value
- store_commit  out  1  one-cycle pulse: head store may go to memory
- store_rob_id  out  ROB_WIDTH_BIT  id of that store
- clear_flag  out  1  one-cycle flush pulse
- redirect_pc  out  32  fetch target, valid with clear_flag

Behaviour:
- Reset values: head=tail=count=0, all busy/ready=0, state=NORMAL. Registered outputs (write_reg_id, write_ROB_id, write_val, store_commit, store_rob_id, clear_flag, redirect_pc) = 0.
- rdy_in low: no state or register changes; issue_accept=0.
- Full/accept:
  - rob_full = (count == ROB_SIZE).
  - issue_accept = rdy_in && issue_valid && !rob_full && state==NORMAL (combinational).
  - Full is evaluated on the pre-edge count, so a same-cycle commit does not free a slot for that cycle's issue.
- Issue: on accept, entry[tail] is set with busy=1, ready=issue_ready, val=issue_val and the fields rd/type/pc/pred; tail wraps modulo ROB_SIZE.
- Writeback: alu_valid sets entry[alu_rob_id] ready, val, taken, target; lsb_valid sets ready and val. Both may fire in the same cycle on distinct ids. A writeback to a non-busy entry is ignored.
- Query (combinational):
  - rsX_ready = entry[rsX_id].ready, OR alu_valid with matching id, OR lsb_valid with matching id.
  - rsX_val forwards in priority ALU, then LSB, then stored val.
- Commit: one per cycle, when state==NORMAL and entry[head] is busy and ready. On the following edge:
  - write_reg_id <= rd (STORE and BRANCH with rd=0 drive 0); write_ROB_id <= head; write_val <= val.
  - STORE: store_commit <= 1, store_rob_id <= head.
  - head++, count--, busy cleared.
  - When no commit occurs, write_reg_id <= 0 and store_commit <= 0.
- Mispredict: a BRANCH commit with taken != pred performs the normal commit write (JALR link preserved) and enters state FLUSH.
  - FLUSH (exactly one cycle): clear_flag=1; redirect_pc = taken ? target : pc+4; write_reg_id=0; no issue, no commit, writebacks ignored.
  - At the end of FLUSH: head=tail=count=0, all busy/ready=0, state returns to NORMAL.
- Count: count_next = count + issue_accept − commit; issue and commit in the same cycle keep count unchanged.
- Reset mid-FLUSH or mid-operation: reset wins, giving the reset values above.

Decomposition:
- ROB_WIDTH_BIT, the issue_type encodings and the state encodings belong in the shared const.v.
- Entry storage stays inline.
- One sub-module is natural: rob_fwd_mux, the combinational rs1/rs2 lookup and bypass, instantiated twice.

Test Plan:
- Reset, then issue 8 ALU ops (rd=1..8) with no writeback → issue_accept high 8 cycles, then rob_full=1; a 9th issue_valid is not accepted.
- Issue id0 rd=5; ALU writeback id0 val=0x2A → next edge write_reg_id=5, write_ROB_id=0, write_val=0x2A, count=0.
- Query rs1_id=3 while alu_valid with alu_rob_id=3, alu_val=0x77 in the same cycle → rs1_ready=1, rs1_val=0x77.
- Out-of-order writeback: ids 0,1,2 issued, writeback order 2,1,0 → commits occur in order 0,1,2 on consecutive cycles.
- BRANCH pc=0x100 pred=0, resolved taken=1 target=0x200, two younger entries present → commit cycle, then clear_flag=1 with redirect_pc=0x200, then count=0 and the next issue gets id 0.
- Full ROB with head ready and issue_valid in the same cycle → commit occurs, issue is rejected, and the issue is accepted next cycle.
